svc_rv_div_seq: RTL

- Iterative, multi-cycle sequencer and datapath for the RV32M divide group: DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the single-cycle ALU.
- Drives op_active_ex into the hazard unit, which holds the pipeline while a divide is in flight.
- Result is valid in the single cycle where op_active_ex drops, so the instruction leaves EX with its result.

---
 rtl/svc_rv_div_seq_pkg.sv | 31 +++
 rtl/svc_rv_div_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/svc_rv_div_seq_pkg.sv
// ============================================================================
// svc_rv_div_seq_pkg : divide-group funct3 encodings and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package svc_rv_div_seq_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Per-operation controls captured in the start cycle and used in FIX.
  typedef struct packed {
    logic neg_quo;
    logic neg_rem;
    logic is_rem;
  } div_ctl_t;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/svc_rv_div_seq.sv
// ============================================================================
// svc_rv_div_seq : iterative restoring divider for DIV/DIVU/REM/REMU in EX
// Revision: 1.0
// ============================================================================
`default_nettype none

module svc_rv_div_seq
  import svc_rv_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            op_active_ex,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  div_ctl_t        ctl_q, ctl_d;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN:0]   w_part;
  logic [XLEN:0]   w_sub;
  logic            w_fits;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic            w_unused;

  assign w_signed = f3_is_signed(funct3);
  assign w_a_neg  = w_signed & rs1[XLEN-1];
  assign w_b_neg  = w_signed & rs2[XLEN-1];
  assign w_a_abs  = w_a_neg ? (~rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : rs1;
  assign w_b_abs  = w_b_neg ? (~rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : rs2;
  assign w_div0   = (rs2 == '0);
  assign w_ovf    = w_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only if it does not go negative.
  assign w_part   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign w_fits   = (w_part >= {1'b0, dvs_q});
  assign w_sub    = w_part - {1'b0, dvs_q};

  assign w_quo_fix = ctl_q.neg_quo ? (~quo_q + {{(XLEN-1){1'b0}}, 1'b1}) : quo_q;
  assign w_rem_fix = ctl_q.neg_rem ? (~rem_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                   : rem_q[XLEN-1:0];

  // The remainder never reaches the divisor, so its top bit is always clear.
  assign w_unused = rem_q[XLEN];

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ctl_d    = ctl_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            quo_d         = w_a_abs;
            dvs_d         = w_b_abs;
            rem_d         = '0;
            cnt_d         = '0;
            ctl_d.neg_quo = w_a_neg ^ w_b_neg;
            ctl_d.neg_rem = w_a_neg;
            ctl_d.is_rem  = f3_is_rem(funct3);
            if (w_div0) begin
              result_d = f3_is_rem(funct3) ? rs1 : '1;
              state_d  = S_DONE;
            end else if (w_ovf) begin
              result_d = f3_is_rem(funct3) ? '0 : rs1;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = w_fits ? w_sub : w_part;
          quo_d = {quo_q[XLEN-2:0], w_fits};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = ctl_q.is_rem ? w_rem_fix : w_quo_fix;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ctl_q    <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ctl_q    <= ctl_d;
    end
  end

  // Combinational stall so the hazard unit holds the pipe in the start cycle.
  assign op_active_ex = rst_n & ~flush &
                        (((state_q == S_IDLE) & start) |
                         (state_q == S_CALC) | (state_q == S_FIX));
  assign done   = rst_n & ~flush & (state_q == S_DONE);
  assign result = result_q;

endmodule

`default_nettype wire
